// File: rtl/game_ctrl_if.sv
// Signal bundle between the round sequencer and its neighbours: key/mouse
// inputs and the hit test on one side; the score counter, digit renderer and
// status outputs on the other.
// Optional build macro: GAME_PAUSE_EN adds the PAUSE key input.
interface game_ctrl_if;
  logic       START;
  logic       CLICK;
  logic       HIT;
  logic [7:0] score;
`ifdef GAME_PAUSE_EN
  logic       PAUSE;
`endif
  logic       CLICK_DOWN2;
  logic       SCORE_RESET;
  logic [1:0] state;
  logic [6:0] time_left;
  logic [2:0] mole_sel;
  logic [7:0] high_score;
  logic       game_over;

  // Sequencer side
  modport master (
`ifdef GAME_PAUSE_EN
    input  PAUSE,
`endif
    input  START, CLICK, HIT, score,
    output CLICK_DOWN2, SCORE_RESET, state, time_left, mole_sel,
           high_score, game_over
  );

  // Environment side (keys, hit test, score counter, renderer)
  modport slave (
`ifdef GAME_PAUSE_EN
    output PAUSE,
`endif
    output START, CLICK, HIT, score,
    input  CLICK_DOWN2, SCORE_RESET, state, time_left, mole_sel,
           high_score, game_over
  );
endinterface

// File: rtl/game_ctrl.sv
// Whack-a-mole round sequencer: IDLE -> PLAY -> OVER with a seconds
// countdown, LFSR mole placement, click qualification into score pulses,
// score clear at round start and a session high score.
// Optional build macro: GAME_PAUSE_EN adds the PAUSE key and the PAUSED state.
module game_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int ROUND_SEC = 60,
  parameter int MOLE_SEC  = 2,
  parameter int HOLES     = 6
) (
  input logic         CLK,
  input logic         RESET,
  game_ctrl_if.master gif
);

  // state  | meaning
  // IDLE   | power-up, waiting for START; time_left parked at ROUND_SEC
  // PLAY   | round running: prescaler, countdown, mole moves, hit scoring
  // OVER   | round done: time_left=0, high score tracking, waiting for START
  // PAUSED | (GAME_PAUSE_EN only) round frozen until the next PAUSE edge

`ifdef GAME_PAUSE_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PLAY   = 2'b01,
    S_OVER   = 2'b10,
    S_PAUSED = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;
`endif

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              MW        = (MOLE_SEC > 1) ? $clog2(MOLE_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_TC  = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0]   MCNT_TC   = MW'(MOLE_SEC - 1);
  localparam logic [6:0]      ROUND_T   = 7'(ROUND_SEC);
  localparam logic [7:0]      HOLES_B   = 8'(HOLES);
  localparam logic [7:0]      LFSR_SEED = 8'hA5;

  // Registered state and outputs
  state_t          state_r, state_nxt;
  logic [6:0]      time_r, time_nxt;
  logic [PW-1:0]   presc_r, presc_nxt;
  logic [MW-1:0]   mcnt_r, mcnt_nxt;
  logic [7:0]      lfsr_r, lfsr_nxt;
  logic [2:0]      mole_r, mole_nxt;
  logic [7:0]      high_r, high_nxt;
  logic            click_dn_r, click_dn_nxt;
  logic            score_rst_r, score_rst_nxt;
  logic            game_over_r;

  // Edge detection history
  logic            start_q, start_prev;
  logic            click_q, click_prev;
  logic            start_edge, click_edge;

  logic            sec_tick;
  logic            mole_step;
  logic [7:0]      lfsr_adv;
  logic [2:0]      mole_adv;

  // Register the keys once, then compare against the previous sample
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_q    <= 1'b0;
      start_prev <= 1'b0;
      click_q    <= 1'b0;
      click_prev <= 1'b0;
    end else begin
      start_q    <= gif.START;
      start_prev <= start_q;
      click_q    <= gif.CLICK;
      click_prev <= click_q;
    end
  end

  assign start_edge = start_q & ~start_prev;
  assign click_edge = click_q & ~click_prev;

`ifdef GAME_PAUSE_EN
  logic pause_q, pause_prev;
  logic pause_edge;

  // Same single-register edge detect for the pause key
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pause_q    <= 1'b0;
      pause_prev <= 1'b0;
    end else begin
      pause_q    <= gif.PAUSE;
      pause_prev <= pause_q;
    end
  end

  assign pause_edge = pause_q & ~pause_prev;
`endif

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero
  assign lfsr_adv = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  assign mole_adv = 3'(lfsr_adv % HOLES_B);

  // Next-state and next-output logic for the round sequencer
  always_comb begin
    state_nxt     = state_r;
    time_nxt      = time_r;
    presc_nxt     = presc_r;
    mcnt_nxt      = mcnt_r;
    lfsr_nxt      = lfsr_r;
    mole_nxt      = mole_r;
    high_nxt      = high_r;
    click_dn_nxt  = 1'b0;
    score_rst_nxt = 1'b0;
    sec_tick      = 1'b0;
    mole_step     = 1'b0;

    case (state_r)
      S_IDLE: begin
        time_nxt  = ROUND_T;
        presc_nxt = '0;
        if (start_edge) begin
          state_nxt     = S_PLAY;
          score_rst_nxt = 1'b1;
          mcnt_nxt      = '0;
        end
      end

      S_PLAY: begin
        sec_tick  = (presc_r == PRESC_TC);
        presc_nxt = sec_tick ? '0 : presc_r + 1'b1;
        if (sec_tick) begin
          if (time_r == 7'd1) begin
            time_nxt  = 7'd0;
            state_nxt = S_OVER;
          end else begin
            time_nxt = time_r - 7'd1;
          end
          if (mcnt_r == MCNT_TC) begin
            mcnt_nxt  = '0;
            mole_step = 1'b1;
          end else begin
            mcnt_nxt = mcnt_r + 1'b1;
          end
        end
        // The pulse cycle of an accepted hit moves the mole on the next edge
        if (click_dn_r) begin
          mole_step = 1'b1;
        end
`ifdef GAME_PAUSE_EN
        // Round end takes priority over a pause request on the same edge
        if (pause_edge && state_nxt == S_PLAY) begin
          state_nxt = S_PAUSED;
        end
`endif
        // Hits are only scored while the round stays live across this edge
        if (click_edge && gif.HIT && state_nxt == S_PLAY) begin
          click_dn_nxt = 1'b1;
        end
      end

      S_OVER: begin
        time_nxt  = 7'd0;
        presc_nxt = '0;
        // Runs every OVER cycle so a late final increment is still captured
        if (gif.score > high_r) begin
          high_nxt = gif.score;
        end
        if (start_edge) begin
          state_nxt     = S_PLAY;
          time_nxt      = ROUND_T;
          score_rst_nxt = 1'b1;
          mcnt_nxt      = '0;
        end
      end

`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (pause_edge) begin
          state_nxt = S_PLAY;
        end
      end
`endif

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (mole_step) begin
      lfsr_nxt = lfsr_adv;
      mole_nxt = mole_adv;
    end
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      time_r      <= ROUND_T;
      presc_r     <= '0;
      mcnt_r      <= '0;
      lfsr_r      <= LFSR_SEED;
      mole_r      <= 3'd0;
      high_r      <= 8'd0;
      click_dn_r  <= 1'b0;
      score_rst_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      time_r      <= time_nxt;
      presc_r     <= presc_nxt;
      mcnt_r      <= mcnt_nxt;
      lfsr_r      <= lfsr_nxt;
      mole_r      <= mole_nxt;
      high_r      <= high_nxt;
      click_dn_r  <= click_dn_nxt;
      score_rst_r <= score_rst_nxt;
      game_over_r <= (state_nxt == S_OVER);
    end
  end

  assign gif.state       = state_r;
  assign gif.time_left   = time_r;
  assign gif.mole_sel    = mole_r;
  assign gif.high_score  = high_r;
  assign gif.CLICK_DOWN2 = click_dn_r;
  assign gif.SCORE_RESET = score_rst_r;
  assign gif.game_over   = game_over_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with TICK_DIV=4, ROUND_SEC=3, MOLE_SEC=2,
// HOLES=6. Expected values are hand-derived cycle positions relative to the
// first PLAY cycle (p0). Mole indices follow the LFSR from seed A5:
// 4A (mod 6 = 2), 95 (mod 6 = 5).
module tb_game_ctrl;
  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  game_ctrl_if bus();

  game_ctrl #(
    .TICK_DIV (4),
    .ROUND_SEC(3),
    .MOLE_SEC (2),
    .HOLES    (6)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .gif  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise START and wait (bounded) for the first PLAY cycle
  task automatic launch(output int lat, output int n_sr);
    lat  = 0;
    n_sr = 0;
    bus.START = 1'b1;
    while (bus.state !== 2'b01 && lat < 8) begin
      step();
      lat++;
      n_sr += int'(bus.SCORE_RESET);
    end
    check("enter_play", bus.state, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n_sr, n_cd;

    RESET     = 1'b1;
    bus.START = 1'b0;
    bus.CLICK = 1'b0;
    bus.HIT   = 1'b0;
    bus.score = 8'd0;
`ifdef GAME_PAUSE_EN
    bus.PAUSE = 1'b0;
`endif
    step();
    step();
    check("rst_state", bus.state, 0);
    check("rst_time", bus.time_left, 3);
    check("rst_high", bus.high_score, 0);
    check("rst_mole", bus.mole_sel, 0);
    check("rst_pulses", {bus.CLICK_DOWN2, bus.SCORE_RESET, bus.game_over}, 0);
    RESET = 1'b0;
    step();

    // Round 1: START held 5 cycles, hit, held click, miss, final score 7 -> 8
    launch(lat, n_sr);
    check("r1_sr_p0", bus.SCORE_RESET, 1);
    n_cd = 0;
    for (int p = 0; p <= 14; p++) begin
      if (p > 0) n_sr += int'(bus.SCORE_RESET);
      n_cd += int'(bus.CLICK_DOWN2);
      if (p == 0) check("r1_time_p0", bus.time_left, 3);
      if (p == 2) check("r1_hit_pulse", bus.CLICK_DOWN2, 1);
      if (p == 3) check("r1_mole_hit", bus.mole_sel, 2);
      if (p == 4) check("r1_time_p4", bus.time_left, 2);
      if (p == 8) check("r1_time_p8", bus.time_left, 1);
      if (p == 8) check("r1_mole_tick", bus.mole_sel, 5);
      if (p == 11) check("r1_state_p11", bus.state, 1);
      if (p == 12) check("r1_state_p12", bus.state, 2);
      if (p == 12) check("r1_time_p12", bus.time_left, 0);
      if (p == 12) check("r1_game_over", bus.game_over, 1);
      if (p == 13) check("r1_high_p13", bus.high_score, 7);
      if (p == 14) check("r1_high_p14", bus.high_score, 8);

      bus.START = (lat + p + 1 < 5);
      if (p == 0) begin bus.CLICK = 1'b1; bus.HIT = 1'b1; bus.score = 8'd7; end
      if (p == 4) bus.CLICK = 1'b0;
      if (p == 5) begin bus.CLICK = 1'b1; bus.HIT = 1'b0; end
      if (p == 8) bus.CLICK = 1'b0;
      if (p == 13) bus.score = 8'd8;
      step();
    end
    check("r1_sr_count", n_sr, 1);
    check("r1_cd_count", n_cd, 1);

    // Round 2: restart from OVER, ignored mid-round START, dropped last hit
    bus.START = 1'b0;
    bus.score = 8'd5;
    step();
    launch(lat, n_sr);
    check("r2_sr_p0", bus.SCORE_RESET, 1);
    check("r2_time_p0", bus.time_left, 3);
    n_sr = 0;
    n_cd = 0;
    for (int p = 0; p <= 13; p++) begin
      if (p > 0) n_sr += int'(bus.SCORE_RESET);
      n_cd += int'(bus.CLICK_DOWN2);
      if (p == 6) check("r2_state_p6", bus.state, 1);
      if (p == 6) check("r2_time_p6", bus.time_left, 2);
      if (p == 12) check("r2_state_p12", bus.state, 2);
      if (p == 12) check("r2_drop_hit", bus.CLICK_DOWN2, 0);
      if (p == 13) check("r2_high_kept", bus.high_score, 8);

      if (p == 1) bus.START = 1'b0;
      if (p == 3) bus.START = 1'b1;
      if (p == 5) bus.START = 1'b0;
      if (p == 10) begin bus.CLICK = 1'b1; bus.HIT = 1'b1; end
      step();
    end
    check("r2_sr_count", n_sr, 0);
    check("r2_cd_count", n_cd, 0);
    bus.CLICK = 1'b0;
    bus.HIT   = 1'b0;
    step();

    // Round 3: RESET mid-PLAY with time_left=2
    launch(lat, n_sr);
    bus.START = 1'b0;
    for (int p = 0; p < 4; p++) step();
    check("r3_time_p4", bus.time_left, 2);
    RESET = 1'b1;
    step();
    check("r3_rst_state", bus.state, 0);
    check("r3_rst_time", bus.time_left, 3);
    check("r3_rst_high", bus.high_score, 0);
    check("r3_rst_mole", bus.mole_sel, 0);
    RESET = 1'b0;
    step();

`ifdef GAME_PAUSE_EN
    // Pause for 10 cycles from PLAY; the round ends 10 cycles late
    launch(lat, n_sr);
    n_cd = 0;
    for (int p = 0; p <= 22; p++) begin
      n_cd += int'(bus.CLICK_DOWN2);
      if (p == 3) check("pz_state_p3", bus.state, 3);
      if (p == 12) check("pz_state_p12", bus.state, 3);
      if (p == 12) check("pz_time_p12", bus.time_left, 3);
      if (p == 12) check("pz_mole_p12", bus.mole_sel, 0);
      if (p == 13) check("pz_state_p13", bus.state, 1);
      if (p == 14) check("pz_time_p14", bus.time_left, 2);
      if (p == 21) check("pz_state_p21", bus.state, 1);
      if (p == 22) check("pz_state_p22", bus.state, 2);

      if (p == 1) begin bus.START = 1'b0; bus.PAUSE = 1'b1; end
      if (p == 3) bus.PAUSE = 1'b0;
      if (p == 5) begin bus.CLICK = 1'b1; bus.HIT = 1'b1; end
      if (p == 7) bus.CLICK = 1'b0;
      if (p == 11) bus.PAUSE = 1'b1;
      if (p == 13) bus.PAUSE = 1'b0;
      step();
    end
    check("pz_cd_count", n_cd, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
